// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: data-memory op codes, FSM states,
// exception kinds and the op normalisation helper.
package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        DM_W  = 3'd0,
        DM_H  = 3'd1,
        DM_HU = 3'd2,
        DM_B  = 3'd3,
        DM_BU = 3'd4
    } dm_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_ADEL = 2'd1,
        EXC_ADES = 2'd2,
        EXC_BUS  = 2'd3
    } exc_e;

    // Unused op encodings behave as a full-word access.
    function automatic dm_op_e norm_op(input logic [2:0] op);
        dm_op_e v;
        case (op)
            3'd1:    v = DM_H;
            3'd2:    v = DM_HU;
            3'd3:    v = DM_B;
            3'd4:    v = DM_BU;
            default: v = DM_W;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational lane logic: byte enables, store-data replication, misalignment
// detection and sign/zero extension of the selected load lane.
module lsu_ctrl_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);

    dm_op_e      w_op;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension per access size
    always_comb begin
        w_op       = norm_op(i_op);
        w_byte     = i_rdata[{i_off, 3'b000} +: 8];
        w_half     = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        o_rdata    = i_rdata;
        case (w_op)
            DM_B, DM_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (w_op == DM_B) ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
            end
            DM_H, DM_HU: begin
                o_be       = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_off[0];
                o_rdata    = (w_op == DM_H) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            end
            default: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_misalign = |i_off;
                o_rdata    = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between the CPU memory stage and a word-wide data memory:
// accepts one access, issues a held word request, returns extended data or an exception.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic [31:0] exc_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic [2:0]  r_op;
    logic        r_we;
    logic [1:0]  r_off;
    logic [31:0] r_pc;
    logic [CW-1:0] r_cnt;

    logic        w_accept;
    logic        w_done;
    exc_e        w_exc;
    logic [2:0]  w_op_sel;
    logic [1:0]  w_off_sel;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic        w_misalign;
    logic [31:0] w_rdata_ext;

    // In IDLE the lane logic looks at the incoming request, afterwards at the latched one.
    assign w_op_sel  = (r_state == ST_IDLE) ? req_op : r_op;
    assign w_off_sel = (r_state == ST_IDLE) ? req_addr[1:0] : r_off;
    assign req_ready = (r_state == ST_IDLE);
    assign stall     = ~req_ready | req_valid;

    lsu_ctrl_align u_align (
        .i_op       (w_op_sel),
        .i_off      (w_off_sel),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata_rep),
        .o_misalign (w_misalign),
        .o_rdata    (w_rdata_ext)
    );

    // Next-state and transaction events
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_exc       = EXC_NONE;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_misalign) begin
                        w_state_nxt = ST_FAULT;
                        w_exc       = req_we ? EXC_ADES : EXC_ADEL;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    w_state_nxt = ST_DONE;
                    w_done      = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT - 32'd1)) begin
                    w_state_nxt = ST_FAULT;
                    w_exc       = EXC_BUS;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_FAULT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latches, memory interface, response and exception registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= 3'd0;
            r_we       <= 1'b0;
            r_off      <= 2'd0;
            r_pc       <= 32'h0;
            r_cnt      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            exc_bus    <= 1'b0;
            exc_pc     <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            exc_adel   <= (w_exc == EXC_ADEL);
            exc_ades   <= (w_exc == EXC_ADES);
            exc_bus    <= (w_exc == EXC_BUS);
            if (w_exc != EXC_NONE) begin
                exc_pc <= (r_state == ST_IDLE) ? req_pc : r_pc;
            end
            if (w_accept) begin
                r_op  <= req_op;
                r_we  <= req_we;
                r_off <= req_addr[1:0];
                r_pc  <= req_pc;
                r_cnt <= '0;
                if (!w_misalign) begin
                    mem_req   <= 1'b1;
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_be    <= w_be;
                    mem_wdata <= w_wdata_rep;
                end
            end
            if (r_state == ST_BUSY) begin
                if (w_done || (w_exc == EXC_BUS)) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    mem_be  <= 4'h0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_done) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= r_we ? 32'h0 : w_rdata_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized accesses checked against
// an arithmetic model of sizes, lanes, extension and response timing.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_adel, exc_ades, exc_bus;
    logic [31:0] exc_pc;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus), .exc_pc(exc_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes; unknown codes are words.
    function automatic int m_size(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % m_size(op)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] op, input logic [31:0] addr);
        int sz;
        sz = m_size(op);
        return 32'(((1 << sz) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        int sz;
        sz = m_size(op);
        if (sz == 1) return {24'h0, wd[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int sz;
        logic [31:0] mask, v;
        sz = m_size(op);
        mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v = (rd >> (8 * int'(addr[1:0]))) & mask;
        if ((op == 3'd1 || op == 3'd3) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // One access from IDLE; delay = BUSY cycles before ack (>= TIMEOUT means none).
    task automatic txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] rd,
                       input int delay);
        int k;
        logic mis;
        mis = m_mis(op, addr);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
        #1;
        chk("stall_req", stall, 1);
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
        req_op = 3'($urandom_range(0, 7)); req_we = 1'($urandom_range(0, 1));
        if (mis) begin
            chk("adel", exc_adel, !we);
            chk("ades", exc_ades, we);
            chk("exc_pc", exc_pc, pc);
            chk("mis_noreq", mem_req, 0);
            chk("mis_noresp", resp_valid, 0);
            step();
            chk("exc_pulse", {exc_adel, exc_ades, exc_bus}, 0);
            chk("mis_noreq2", mem_req, 0);
            chk("ready_back", req_ready, 1);
        end else begin
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            chk("mem_be", mem_be, m_be(op, addr));
            chk("mem_we", mem_we, we);
            if (we) chk("mem_wdata", mem_wdata, m_wdata(op, wd));
            chk("ready_busy", req_ready, 0);
            k = 0;
            while (k < delay && k < TIMEOUT) begin
                chk("req_held", mem_req, 1);
                step();
                k++;
            end
            if (k < TIMEOUT) begin
                chk("req_at_ack", mem_req, 1);
                chk("addr_stable", mem_addr, {addr[31:2], 2'b00});
                mem_ack = 1'b1; mem_rdata = rd;
                step();
                mem_ack = 1'b0; mem_rdata = $urandom;
                chk("resp_valid", resp_valid, 1);
                chk("resp_rdata", resp_rdata, we ? 32'h0 : m_load(op, addr, rd));
                chk("req_drop", mem_req, 0);
                chk("no_exc", {exc_adel, exc_ades, exc_bus}, 0);
                chk("stall_done", stall, 1);
                step();
                chk("resp_pulse", resp_valid, 0);
                chk("ready_back", req_ready, 1);
            end else begin
                chk("bus_exc", exc_bus, 1);
                chk("bus_pc", exc_pc, pc);
                chk("bus_req_drop", mem_req, 0);
                chk("bus_noresp", resp_valid, 0);
                step();
                chk("bus_pulse", exc_bus, 0);
                chk("ready_back", req_ready, 1);
            end
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_ctl", {mem_req, mem_we, resp_valid, exc_adel, exc_ades, exc_bus}, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_pc", exc_pc, 0);

        txn(1'b1, 3'd0, 32'h10, 32'h12345678, 32'h1000, 32'h0, 2);
        txn(1'b1, 3'd3, 32'h13, 32'h000000AB, 32'h1004, 32'h0, 0);
        txn(0, 3'd3, 32'h12, 32'h0, 32'h1008, 32'h00F00000, 1);
        txn(0, 3'd4, 32'h12, 32'h0, 32'h100C, 32'h00F00000, 0);
        txn(0, 3'd1, 32'h6, 32'h0, 32'h1010, 32'h80011234, 1);
        txn(0, 3'd2, 32'h6, 32'h0, 32'h1014, 32'h80011234, 0);
        txn(0, 3'd0, 32'h6, 32'h0, 32'h3000, 32'h0, 0);
        txn(1'b1, 3'd1, 32'h5, 32'h0000BEEF, 32'h3004, 32'h0, 0);
        txn(1'b1, 3'd6, 32'h44, 32'hCAFEF00D, 32'h3008, 32'h0, 0);
        txn(0, 3'd0, 32'h20, 32'h0, 32'h300C, 32'h0, TIMEOUT + 4);
        txn(0, 3'd0, 32'h24, 32'h0, 32'h3010, 32'hA5A5A5A5, TIMEOUT - 1);

        // Ack while idle must not produce a response
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        chk("idle_ack", {resp_valid, mem_req, exc_bus}, 0);

        // Reset in the middle of an access, then a late ack
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h40; req_pc = 32'h4000;
        step();
        req_valid = 1'b0;
        chk("mid_req", mem_req, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ack = 1'b1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_resp", resp_valid, 0);
        step();
        mem_ack = 1'b0;
        chk("late_ack", {resp_valid, exc_bus, mem_req}, 0);
        chk("late_ready", req_ready, 1);

        // Back-to-back: the held second request waits for the response cycle
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'd0; req_addr = 32'h80; req_wdata = 32'h11;
        step();
        req_we = 1'b0; req_addr = 32'h84;
        chk("b2b_busy", req_ready, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b2b_resp", resp_valid, 1);
        chk("b2b_no_accept", mem_req, 0);
        step();
        chk("b2b_idle", req_ready, 1);
        chk("b2b_stall", stall, 1);
        step();
        req_valid = 1'b0;
        chk("b2b_req2", mem_req, 1);
        chk("b2b_addr2", mem_addr, 32'h84);
        chk("b2b_we2", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 32'h76543210;
        step();
        mem_ack = 1'b0;
        chk("b2b_rdata2", resp_rdata, 32'h76543210);
        step();

        for (int i = 0; i < 40; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, $urandom, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
